// File: rtl/vga_bounce_box.sv
// Bouncing-box pixel stage: two-cycle pipeline from sync-generator inputs to RGB/sync outputs.
// Optional VGA_BOUNCE_BORDER_EN draws a white one-pixel frame around the active area.
module vga_bounce_box #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_W     = 32,
    parameter int          BOX_H     = 24,
    parameter int          STEP      = 2,
    parameter int          INIT_X    = 100,
    parameter int          INIT_Y    = 60,
    parameter logic [11:0] BOX_COLOR = 12'hF80,
    parameter logic [11:0] BG_COLOR  = 12'h008
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hSyncIn,
    input  logic       vSyncIn,
    input  logic [9:0] xIndex,
    input  logic [9:0] yIndex,
    input  logic       displayEnable,
    input  logic       pause,
    output logic       hSync,
    output logic       vSync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       frameTick
);

    logic [9:0]  boxX, boxY, nextX, nextY;
    logic        dirX, dirY, nextDirX, nextDirY;
    logic        vSyncPrev;
    logic        hSync1, vSync1, de1, inBox1;
    logic        inBox;
    logic [10:0] xExt, yExt, boxRight, boxBottom;
    logic [11:0] pixel;

    assign xExt      = {1'b0, xIndex};
    assign yExt      = {1'b0, yIndex};
    assign boxRight  = {1'b0, boxX} + 11'(BOX_W);
    assign boxBottom = {1'b0, boxY} + 11'(BOX_H);
    assign inBox     = (xExt >= {1'b0, boxX}) && (xExt < boxRight) &&
                       (yExt >= {1'b0, boxY}) && (yExt < boxBottom);

    // Direction bit: 1 = increasing coordinate (right/down).
    always_comb begin
        nextX    = boxX;
        nextDirX = dirX;
        if (dirX) begin
            if (boxRight + 11'(STEP) >= 11'(H_ACTIVE)) begin
                nextX    = 10'(H_ACTIVE - BOX_W);
                nextDirX = 1'b0;
            end else begin
                nextX = boxX + 10'(STEP);
            end
        end else begin
            if (boxX < 10'(STEP)) begin
                nextX    = '0;
                nextDirX = 1'b1;
            end else begin
                nextX = boxX - 10'(STEP);
            end
        end
    end

    always_comb begin
        nextY    = boxY;
        nextDirY = dirY;
        if (dirY) begin
            if (boxBottom + 11'(STEP) >= 11'(V_ACTIVE)) begin
                nextY    = 10'(V_ACTIVE - BOX_H);
                nextDirY = 1'b0;
            end else begin
                nextY = boxY + 10'(STEP);
            end
        end else begin
            if (boxY < 10'(STEP)) begin
                nextY    = '0;
                nextDirY = 1'b1;
            end else begin
                nextY = boxY - 10'(STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            boxX      <= 10'(INIT_X);
            boxY      <= 10'(INIT_Y);
            dirX      <= 1'b1;
            dirY      <= 1'b1;
            vSyncPrev <= 1'b1;
            frameTick <= 1'b0;
        end else begin
            vSyncPrev <= vSyncIn;
            frameTick <= vSyncIn & ~vSyncPrev;
            if (frameTick && !pause) begin
                boxX <= nextX;
                boxY <= nextY;
                dirX <= nextDirX;
                dirY <= nextDirY;
            end
        end
    end

`ifdef VGA_BOUNCE_BORDER_EN
    logic border1;

    always_ff @(posedge clk) begin
        if (reset) begin
            border1 <= 1'b0;
        end else begin
            border1 <= (xIndex == '0) || (xIndex == 10'(H_ACTIVE - 1)) ||
                       (yIndex == '0) || (yIndex == 10'(V_ACTIVE - 1));
        end
    end

    always_comb begin
        pixel = '0;
        if (de1) begin
            if (border1)     pixel = 12'hFFF;
            else if (inBox1) pixel = BOX_COLOR;
            else             pixel = BG_COLOR;
        end
    end
`else
    always_comb begin
        pixel = '0;
        if (de1) pixel = inBox1 ? BOX_COLOR : BG_COLOR;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hSync1 <= 1'b1;
            vSync1 <= 1'b1;
            de1    <= 1'b0;
            inBox1 <= 1'b0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else begin
            hSync1 <= hSyncIn;
            vSync1 <= vSyncIn;
            de1    <= displayEnable;
            inBox1 <= inBox;
            hSync  <= hSync1;
            vSync  <= vSync1;
            red    <= pixel[11:8];
            green  <= pixel[7:4];
            blue   <= pixel[3:0];
        end
    end

endmodule
